uart_tx_arb: RTL

Packet-level arbiter and sequencer for the shared debug UART transmitter (`uart_tx`). It sits in `usb_top` between two byte-stream requesters and the single `uart_tx` instance. Requester 0 is the boot status message; requester 1 is the USB data/debug stream. It grants the transmitter for a whole packet (through the byte flagged `last`), paces bytes with `uart_tx`'s active/done handshake, and alternates owners round-robin so streams never interleave mid-packet.

---
 rtl/uart_tx_arb_if.sv | 42 ++++
 rtl/uart_tx_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb_if.sv
// Byte-stream and uart_tx pacing signals shared by the debug UART arbiter.
// master = requesters plus uart_tx side, slave = uart_tx_arb.
interface uart_tx_arb_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic [1:0] grant;
    logic       busy;
    logic       trunc;

    // Handshake: a requester byte moves on a cycle where reqN_valid && reqN_ready.
    // reqN_ready never depends on reqN_valid; a requester holds data/last stable
    // while valid is high and not yet accepted.
    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  tx_dv, tx_byte,
        output tx_active, tx_done,
        input  grant, busy, trunc
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output tx_dv, tx_byte,
        input  tx_active, tx_done,
        output grant, busy, trunc
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter in front of the shared debug uart_tx.
// Optional macro UART_ARB_CRLF_EN appends CR LF after every packet end.
module uart_tx_arb #(
    parameter int MAX_PKT = 128,
    parameter int CNT_W   = 8
) (
    input  logic         clk48,
    input  logic         reset,
    uart_tx_arb_if.slave arb,
    output logic [2:0]   o_state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_LOAD      = 3'd2,
        S_WAIT_ACT  = 3'd3,
        S_WAIT_DONE = 3'd4
`ifdef UART_ARB_CRLF_EN
        ,
        S_CR        = 3'd5,
        S_LF        = 3'd6
`endif
    } state_t;

`ifdef UART_ARB_CRLF_EN
    // Which byte the current LOAD/WAIT sequence carries.
    typedef enum logic [1:0] {
        PH_DATA = 2'd0,
        PH_CR   = 2'd1,
        PH_LF   = 2'd2
    } phase_t;

    phase_t r_phase;
    logic   w_phase_data;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tx_byte;

    logic             w_start;
    logic             w_new_owner;
    logic             w_accept;
    logic             w_release;
    logic             w_at_max;
    logic             w_pkt_end;
    logic             w_sel_valid;
    logic [7:0]       w_sel_data;
    logic             w_sel_last;
    logic             w_busy;

    assign w_sel_valid = r_owner ? arb.req1_valid : arb.req0_valid;
    assign w_sel_data  = r_owner ? arb.req1_data  : arb.req0_data;
    assign w_sel_last  = r_owner ? arb.req1_last  : arb.req0_last;
    assign w_at_max    = (r_cnt == CNT_MAX);
    assign w_pkt_end   = r_last || w_at_max;
    assign w_busy      = (r_state != S_IDLE);

`ifdef UART_ARB_CRLF_EN
    assign w_phase_data = (r_phase == PH_DATA);
`endif

    always_ff @(posedge clk48) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_new_owner = r_owner;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A byte still shifting out of uart_tx (e.g. after a reset) blocks new grants.
                if (!arb.tx_active && (arb.req0_valid || arb.req1_valid)) begin
                    w_start = 1'b1;
                    if (arb.req0_valid && arb.req1_valid) begin
                        w_new_owner = ~r_last_owner;
                    end else begin
                        w_new_owner = arb.req1_valid;
                    end
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_sel_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (arb.tx_active) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (arb.tx_done) begin
`ifdef UART_ARB_CRLF_EN
                    case (r_phase)
                        PH_DATA: w_state_nxt = w_pkt_end ? S_CR : S_SEND;
                        PH_CR:   w_state_nxt = S_LF;
                        default: begin
                            w_state_nxt = S_IDLE;
                            w_release   = 1'b1;
                        end
                    endcase
`else
                    if (w_pkt_end) begin
                        w_state_nxt = S_IDLE;
                        w_release   = 1'b1;
                    end else begin
                        w_state_nxt = S_SEND;
                    end
`endif
                end
            end
`ifdef UART_ARB_CRLF_EN
            S_CR: begin
                w_state_nxt = S_LOAD;
            end
            S_LF: begin
                w_state_nxt = S_LOAD;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        arb.tx_dv      = (r_state == S_LOAD);
        arb.tx_byte    = r_tx_byte;
        arb.busy       = w_busy;
        arb.grant      = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
        arb.req0_ready = (r_state == S_SEND) && !r_owner;
        arb.req1_ready = (r_state == S_SEND) &&  r_owner;
        arb.trunc      = (r_state == S_WAIT_DONE) && arb.tx_done && w_at_max && !r_last;
`ifdef UART_ARB_CRLF_EN
        arb.trunc      = arb.trunc && w_phase_data;
`endif
    end

    always_ff @(posedge clk48) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_last       <= 1'b0;
            r_cnt        <= '0;
            r_tx_byte    <= 8'h00;
`ifdef UART_ARB_CRLF_EN
            r_phase      <= PH_DATA;
`endif
        end else begin
            if (w_start) begin
                r_owner <= w_new_owner;
                r_cnt   <= '0;
`ifdef UART_ARB_CRLF_EN
                r_phase <= PH_DATA;
`endif
            end
            if (w_accept) begin
                r_tx_byte <= w_sel_data;
                r_last    <= w_sel_last;
                // Saturating; only compared against MAX_PKT after a done pulse.
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_release) begin
                r_last_owner <= r_owner;
            end
`ifdef UART_ARB_CRLF_EN
            if (r_state == S_CR) begin
                r_tx_byte <= 8'h0D;
                r_phase   <= PH_CR;
            end
            if (r_state == S_LF) begin
                r_tx_byte <= 8'h0A;
                r_phase   <= PH_LF;
            end
`endif
        end
    end

    assign o_state_dbg = r_state;

    a_dv_not_active: assert property (@(posedge clk48) disable iff (reset)
        arb.tx_dv |-> !arb.tx_active);

    a_grant_onehot: assert property (@(posedge clk48) disable iff (reset)
        $onehot0(arb.grant) && (w_busy == (arb.grant != 2'b00)));

endmodule
